// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: walks hour/minute/second edit fields with mode/inc
// buttons, auto-repeat and idle timeout, and strobes a single load on commit.
module time_set_ctrl #(
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 2,
  parameter int TIMEOUT     = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hr,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       ld_time,
  output logic       run_en,
  output logic [1:0] sel,
  output logic       blink
);

  localparam int HOLD_W = $clog2(REPEAT_DLY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DLY);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(REPEAT_RATE);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  typedef enum logic [2:0] {RUN, S_HR, S_MIN, S_SEC, COMMIT} state_t;

  state_t state_reg, state_next;

  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [RATE_W-1:0] rate_reg, rate_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic [4:0]        set_hr_reg, set_hr_next;
  logic [5:0]        set_min_reg, set_min_next;
  logic [5:0]        set_sec_reg, set_sec_next;
  logic              ld_time_reg, ld_time_next;
  logic              run_en_reg, run_en_next;
  logic [1:0]        sel_reg, sel_next;
  logic              blink_reg, blink_next;

  logic [1:0] btn_lvl;
  logic [1:0] btn_edge;
  logic       mode_edge, inc_edge;
  logic       in_set, next_in_set;
  logic       repeat_fire, timeout, inc_fire;

  // Rising-edge detect per button; prev resets low so a held button yields one edge.
  assign btn_lvl = {btn_inc, btn_mode};
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      logic prev_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_reg <= 1'b0;
        else     prev_reg <= btn_lvl[gi];
      end
      assign btn_edge[gi] = btn_lvl[gi] & ~prev_reg;
    end
  endgenerate

  assign mode_edge = btn_edge[0];
  assign inc_edge  = btn_edge[1];
  assign in_set    = (state_reg == S_HR) || (state_reg == S_MIN) || (state_reg == S_SEC);

  function automatic logic [4:0] hr_inc(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] ms_inc(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    hold_next    = '0;
    rate_next    = '0;
    idle_next    = '0;
    repeat_fire  = 1'b0;
    timeout      = 1'b0;
    inc_fire     = 1'b0;
    state_next   = state_reg;
    set_hr_next  = set_hr_reg;
    set_min_next = set_min_reg;
    set_sec_next = set_sec_reg;

    if (in_set) begin
      // Hold counter saturates at the delay; the rate counter then paces repeats.
      if (btn_inc) begin
        hold_next = hold_reg;
        if (tick && hold_reg != HOLD_MAX)
          hold_next = hold_reg + HOLD_W'(1);
        if (tick && hold_reg == HOLD_MAX - HOLD_W'(1))
          repeat_fire = 1'b1;
        if (hold_reg == HOLD_MAX) begin
          rate_next = rate_reg;
          if (tick) begin
            if (rate_reg == RATE_MAX - RATE_W'(1)) begin
              rate_next   = '0;
              repeat_fire = 1'b1;
            end else begin
              rate_next = rate_reg + RATE_W'(1);
            end
          end
        end
      end
      if (!(mode_edge || inc_edge || btn_inc)) begin
        idle_next = idle_reg;
        if (tick && idle_reg != IDLE_MAX)
          idle_next = idle_reg + IDLE_W'(1);
        timeout = tick && (idle_reg == IDLE_MAX - IDLE_W'(1));
      end
    end

    inc_fire = (inc_edge || repeat_fire) && !mode_edge;

    case (state_reg)
      RUN: begin
        if (mode_edge) begin
          state_next   = S_HR;
          set_hr_next  = cur_hr;
          set_min_next = cur_min;
          set_sec_next = cur_sec;
        end
      end
      S_HR: begin
        if (mode_edge)     state_next  = S_MIN;
        else if (timeout)  state_next  = RUN;
        else if (inc_fire) set_hr_next = hr_inc(set_hr_reg);
      end
      S_MIN: begin
        if (mode_edge)     state_next   = S_SEC;
        else if (timeout)  state_next   = RUN;
        else if (inc_fire) set_min_next = ms_inc(set_min_reg);
      end
      S_SEC: begin
        if (mode_edge)     state_next   = COMMIT;
        else if (timeout)  state_next   = RUN;
        else if (inc_fire) set_sec_next = ms_inc(set_sec_reg);
      end
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase

    if (state_next != state_reg) begin
      hold_next = '0;
      rate_next = '0;
      idle_next = '0;
    end
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    next_in_set  = (state_next == S_HR) || (state_next == S_MIN) || (state_next == S_SEC);
    ld_time_next = (state_next == COMMIT);
    run_en_next  = (state_next == RUN);
    case (state_next)
      S_HR:    sel_next = 2'd1;
      S_MIN:   sel_next = 2'd2;
      S_SEC:   sel_next = 2'd3;
      default: sel_next = 2'd0;
    endcase
    blink_next = 1'b0;
    if (next_in_set && state_reg != RUN)
      blink_next = blink_reg ^ tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RUN;
      hold_reg    <= '0;
      rate_reg    <= '0;
      idle_reg    <= '0;
      set_hr_reg  <= '0;
      set_min_reg <= '0;
      set_sec_reg <= '0;
      ld_time_reg <= 1'b0;
      run_en_reg  <= 1'b1;
      sel_reg     <= 2'd0;
      blink_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      rate_reg    <= rate_next;
      idle_reg    <= idle_next;
      set_hr_reg  <= set_hr_next;
      set_min_reg <= set_min_next;
      set_sec_reg <= set_sec_next;
      ld_time_reg <= ld_time_next;
      run_en_reg  <= run_en_next;
      sel_reg     <= sel_next;
      blink_reg   <= blink_next;
    end
  end

  assign set_hr  = set_hr_reg;
  assign set_min = set_min_reg;
  assign set_sec = set_sec_reg;
  assign ld_time = ld_time_reg;
  assign run_en  = run_en_reg;
  assign sel     = sel_reg;
  assign blink   = blink_reg;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Sequencer for the clock's time-setting path. Walks the user through hour, minute and second fields with two buttons. Holds editable working copies of each field, with wrap-around and auto-repeat. Pulses a single load strobe to the time counters on commit, and freezes counting while editing. It sits between the button synchronizers and the hour/minute/second counter datapath, and drives the field-select and blink inputs of the display mux.

Parameters:
REPEAT_DLY, 8, ticks btn_inc must be held before auto-repeat starts
REPEAT_RATE, 2, ticks between auto-repeat increments
TIMEOUT, 40, ticks with no button edge before an edit is abandoned

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle pulse at the slow UI rate (4 Hz)
btn_mode  in  1  mode button level, already synchronized/debounced
btn_inc  in  1  increment button level, already synchronized/debounced
cur_hr  in  5  live hour value, 0-23
cur_min  in  6  live minute value, 0-59
cur_sec  in  6  live second value, 0-59
set_hr  out  5  working hour value
set_min  out  6  working minute value
set_sec  out  6  working second value
ld_time  out  1  one-cycle load strobe to the time counters
run_en  out  1  counter enable; 1 only in RUN
sel  out  2  field select: 0=none, 1=hr, 2=min, 3=sec
blink  out  1  blink phase for the selected field

Behaviour:
- Reset (async, active-high):
  - state=RUN, set_*=0, ld_time=0, run_en=1, sel=0, blink=0.
  - All counters cleared.
  - Reset asserted mid-edit abandons the edit with no load.
- Edge detect:
  - Each button is registered; edge = level & ~prev.
  - prev resets to 0, so a button held through reset release produces one edge.
- States: RUN, S_HR, S_MIN, S_SEC, COMMIT. All outputs are registered, Moore-decoded from the next state (valid the cycle after the causing edge).
- RUN:
  - run_en=1.
  - On a mode edge, capture cur_hr/min/sec into set_*, then go to S_HR.
  - inc edges are ignored.
- Mode edge transitions: S_HR -> S_MIN -> S_SEC -> COMMIT.
- COMMIT:
  - Lasts exactly one cycle with ld_time=1, then RUN.
  - ld_time is never high in any other state.
- Increment (set states only), applied to the selected field:
  - hr: 23 -> 0.
  - min/sec: 59 -> 0.
  - Other fields are untouched.
- Auto-repeat:
  - The hold counter counts ticks while btn_inc=1 and clears when btn_inc=0.
  - When it reaches REPEAT_DLY, one increment occurs, then one more every REPEAT_RATE further ticks while held.
  - The hold counter also clears on any state change.
- Simultaneous mode and inc edges in the same cycle: mode wins; the inc edge is dropped and the hold counter cleared.
- Timeout:
  - The idle counter counts ticks in set states and clears on any button edge and while btn_inc is held.
  - When it reaches TIMEOUT, go to RUN without COMMIT (ld_time stays 0); set_* keep their values.
- blink: toggles on every tick in set states; forced to 0 in RUN/COMMIT and on entry to S_HR.
- sel: 1/2/3 in S_HR/S_MIN/S_SEC; 0 otherwise.
- run_en: 0 in set states and COMMIT.
- Counter widths: sized to hold their parameter value; they saturate at the parameter value and never wrap.

Test Plan:
1. Reset mid-S_MIN with set_min=17 -> outputs return at once to RUN values; no ld_time pulse.
2. cur=13:45:30. Sequence: mode edge, 11 inc edges, mode edge, mode edge, mode edge.
   - Required: set_hr 13 -> 0 (wraps after 23), S_MIN and S_SEC untouched.
   - Exactly one ld_time pulse, carrying 0:45:30.
   - run_en low from the first mode edge until the cycle after COMMIT.
3. In S_MIN with set_min=58, hold btn_inc for 14 ticks.
   - Required: edge gives 59; tick 8 gives 0; ticks 10, 12, 14 give 1, 2, 3.
   - Release stops increments.
4. In S_SEC, idle for 40 ticks -> RUN on the 40th tick with ld_time=0 throughout. An inc edge at tick 39 restarts the count.
5. In S_HR, mode and inc edges in the same cycle -> S_MIN; set_hr unchanged.
6. In RUN, inc edges and a held btn_inc -> set_* unchanged, run_en=1, sel=0, blink=0.
